// File: rtl/regfile_mp_pkg.sv
// Shared constants, defaults and FSM encoding for the multi-port register file.
package regfile_mp_pkg;

  localparam logic        RstEnable   = 1'b1;
  localparam logic        WriteEnable = 1'b1;
  localparam logic        ReadEnable  = 1'b1;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_NUM_REGS = 32;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // True for an address that names a real, writable register (not r0, not beyond the file).
  function automatic logic addr_in_range(input int unsigned addr, input int unsigned num_regs);
    return (addr != 0) && (addr < num_regs);
  endfunction

endpackage

// File: rtl/regfile_wr_arb.sv
// Resolves all write ports against one address: reports whether any enabled
// write hits it and which data wins (highest-index port takes priority).
module regfile_wr_arb
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_WR = 2
) (
  input  logic [NUM_WR-1:0]        we_i,
  input  logic [NUM_WR*ADDR_W-1:0] waddr_i,
  input  logic [NUM_WR*DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0]        addr_i,
  output logic                     hit_o,
  output logic [DATA_W-1:0]        data_o
);

  // Scan ports in ascending order so a later (higher-index) match overrides earlier ones.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      if ((we_i[k] == WriteEnable) && (waddr_i[k*ADDR_W +: ADDR_W] == addr_i)) begin
        hit_o  = 1'b1;
        data_o = wdata_i[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write priority, optional write-to-read bypass,
// a pending scoreboard for hazard detection and a post-reset zeroing sweep.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rvalid,
  input  logic                     mark,
  input  logic [ADDR_W-1:0]        mark_addr,
  output logic                     init_done
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REGS-1:1] pend_q, pend_d;
  logic [DATA_W-1:0]   mem_q [1:NUM_REGS-1];
  logic [DATA_W-1:0]   mem_d [1:NUM_REGS-1];

  logic                wr_hit  [1:NUM_REGS-1];
  logic [DATA_W-1:0]   wr_data [1:NUM_REGS-1];
  logic                byp_hit  [NUM_RD];
  logic [DATA_W-1:0]   byp_data [NUM_RD];

  logic run_act;
  logic clear_act;

  assign run_act   = (state_q == ST_RUN) && (rst != RstEnable);
  assign clear_act = (state_q == ST_CLEAR) && (rst != RstEnable);
  assign init_done = run_act;

  // Storage write decode: one resolver per physical register (r0 has no storage).
  for (genvar r = 1; r < NUM_REGS; r++) begin : g_wdec
    regfile_wr_arb #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .NUM_WR(NUM_WR)
    ) u_wdec (
      .we_i   (we),
      .waddr_i(waddr),
      .wdata_i(wdata),
      .addr_i (ADDR_W'(r)),
      .hit_o  (wr_hit[r]),
      .data_o (wr_data[r])
    );
  end

  // Bypass resolution: one resolver per read port.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_byp
    regfile_wr_arb #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .NUM_WR(NUM_WR)
    ) u_byp (
      .we_i   (we),
      .waddr_i(waddr),
      .wdata_i(wdata),
      .addr_i (raddr[i*ADDR_W +: ADDR_W]),
      .hit_o  (byp_hit[i]),
      .data_o (byp_data[i])
    );
  end

  // Sweep sequencing: walk the counter from 1 to NUM_REGS-1, then enter RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(NUM_REGS - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q;
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = ADDR_W'(1);
      end
    endcase
  end

  // FSM, sweep counter and scoreboard registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= ST_CLEAR;
      cnt_q   <= ADDR_W'(1);
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Next contents of storage: the sweep zeroes one register per cycle, RUN applies resolved writes.
  always_comb begin
    mem_d = mem_q;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (clear_act && (cnt_q == ADDR_W'(r))) begin
        mem_d[r] = DATA_W'(ZeroWord);
      end else if (run_act && wr_hit[r]) begin
        mem_d[r] = wr_data[r];
      end
    end
  end

  // Storage array has no reset; the sweep provides the zero state.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Scoreboard update: writes clear, a mark sets; the mark is applied last so it wins.
  always_comb begin
    pend_d = pend_q;
    if (run_act) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (wr_hit[r]) begin
          pend_d[r] = 1'b0;
        end
      end
      if (mark) begin
        for (int r = 1; r < NUM_REGS; r++) begin
          if (mark_addr == ADDR_W'(r)) begin
            pend_d[r] = 1'b1;
          end
        end
      end
    end
  end

  // Combinational read ports: gating, r0/out-of-range, bypass, then stored value and pending.
  always_comb begin
    rdata  = '0;
    rvalid = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] sto_data;
      logic              sto_pend;
      a        = raddr[i*ADDR_W +: ADDR_W];
      sto_data = '0;
      sto_pend = 1'b0;
      for (int r = 1; r < NUM_REGS; r++) begin
        if (a == ADDR_W'(r)) begin
          sto_data = mem_q[r];
          sto_pend = pend_q[r];
        end
      end
      if (run_act && (re[i] == ReadEnable)) begin
        if (!addr_in_range(32'(a), NUM_REGS)) begin
          rvalid[i] = 1'b1;
        end else if ((BYPASS != 0) && byp_hit[i]) begin
          rdata[i*DATA_W +: DATA_W] = byp_data[i];
          rvalid[i]                 = 1'b1;
        end else begin
          rdata[i*DATA_W +: DATA_W] = sto_data;
          rvalid[i]                 = !sto_pend;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  we, re;
  logic [9:0]  waddr, raddr;
  logic [63:0] wdata;
  logic        mark;
  logic [4:0]  mark_addr;

  logic [63:0] rd_b, rd_n;
  logic [1:0]  rv_b, rv_n;
  logic        id_b, id_n;

  logic [31:0] m_mem [32];
  bit          m_pend [32];
  bit          m_run;
  int          m_left;

  int total = 0;
  int bad   = 0;
  int edges;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .re(re), .raddr(raddr),
    .rdata(rd_b), .rvalid(rv_b), .mark(mark), .mark_addr(mark_addr), .init_done(id_b));

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(0)) dut_n (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .re(re), .raddr(raddr),
    .rdata(rd_n), .rvalid(rv_n), .mark(mark), .mark_addr(mark_addr), .init_done(id_n));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference read: what port i should return given the current inputs and model state.
  task automatic model_read(input int i, input bit byp, output logic [31:0] d, output logic v);
    logic [4:0] a;
    bit hit;
    d = '0; v = 1'b0; hit = 1'b0;
    if (rst || !m_run || !re[i]) return;
    a = raddr[i*5 +: 5];
    if (a == 0) begin v = 1'b1; return; end
    if (byp) begin
      for (int k = 0; k < 2; k++)
        if (we[k] && waddr[k*5 +: 5] == a) begin d = wdata[k*32 +: 32]; hit = 1'b1; end
      if (hit) begin v = 1'b1; return; end
    end
    d = m_mem[a];
    v = !m_pend[a];
  endtask

  task automatic model_edge();
    logic [4:0] a;
    if (rst) begin
      m_run = 1'b0; m_left = 31;
      for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
    end else if (!m_run) begin
      m_left--;
      if (m_left == 0) begin
        m_run = 1'b1;
        for (int r = 0; r < 32; r++) m_mem[r] = '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        a = waddr[k*5 +: 5];
        if (we[k] && a != 0) begin m_mem[a] = wdata[k*32 +: 32]; m_pend[a] = 1'b0; end
      end
      if (mark && mark_addr != 0) m_pend[mark_addr] = 1'b1;
    end
  endtask

  task automatic sample();
    logic [31:0] d;
    logic v;
    #2;
    chk("init_done_byp", {63'd0, id_b}, {63'd0, m_run && !rst});
    chk("init_done_nobyp", {63'd0, id_n}, {63'd0, m_run && !rst});
    for (int i = 0; i < 2; i++) begin
      model_read(i, 1'b1, d, v);
      chk($sformatf("rdata_byp[%0d]", i), {32'd0, rd_b[i*32 +: 32]}, {32'd0, d});
      chk($sformatf("rvalid_byp[%0d]", i), {63'd0, rv_b[i]}, {63'd0, v});
      model_read(i, 1'b0, d, v);
      chk($sformatf("rdata_nobyp[%0d]", i), {32'd0, rd_n[i*32 +: 32]}, {32'd0, d});
      chk($sformatf("rvalid_nobyp[%0d]", i), {63'd0, rv_n[i]}, {63'd0, v});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic cycle();
    sample();
    tick();
  endtask

  task automatic idle();
    we = '0; re = '0; mark = 1'b0;
    waddr = '0; wdata = '0; raddr = '0; mark_addr = '0;
  endtask

  task automatic count_sweep(input string tag);
    edges = 0;
    while (!id_b && edges < 100) begin
      cycle();
      edges++;
    end
    chk(tag, 64'(edges), 64'd31);
  endtask

  initial begin
    m_run = 1'b0; m_left = 31;
    for (int r = 0; r < 32; r++) begin m_mem[r] = '0; m_pend[r] = 1'b0; end
    rst = 1'b1;
    idle();
    re = 2'b11; raddr = {5'd2, 5'd0};
    @(negedge clk);
    cycle();
    cycle();

    // Sweep with a write and mark to r5 that must be ignored.
    rst = 1'b0;
    we = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'd0, 32'hCAFE_F00D};
    mark = 1'b1; mark_addr = 5'd5;
    re = 2'b11; raddr = {5'd5, 5'd5};
    count_sweep("sweep_edges");
    idle();
    re = 2'b01; raddr = {5'd0, 5'd5};
    sample();
    chk("r5_after_sweep", {32'd0, rd_b[31:0]}, 64'd0);
    chk("r5_valid_after_sweep", {63'd0, rv_b[0]}, 64'd1);
    tick();

    // Write priority.
    idle();
    we = 2'b11; waddr = {5'd7, 5'd7}; wdata = {32'h22, 32'h11};
    cycle();
    idle();
    re = 2'b01; raddr = {5'd0, 5'd7};
    sample();
    chk("prio_r7", {32'd0, rd_b[31:0]}, 64'h22);
    tick();

    // Bypass vs no bypass.
    idle();
    we = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'd0, 32'h1234};
    cycle();
    idle();
    we = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'd0, 32'hDEAD};
    re = 2'b01; raddr = {5'd0, 5'd3};
    sample();
    chk("bypass_data", {32'd0, rd_b[31:0]}, 64'hDEAD);
    chk("bypass_valid", {63'd0, rv_b[0]}, 64'd1);
    chk("nobypass_old", {32'd0, rd_n[31:0]}, 64'h1234);
    tick();
    idle();
    re = 2'b01; raddr = {5'd0, 5'd3};
    sample();
    chk("nobypass_next", {32'd0, rd_n[31:0]}, 64'hDEAD);
    tick();

    // Scoreboard.
    idle();
    mark = 1'b1; mark_addr = 5'd9;
    cycle();
    idle();
    re = 2'b01; raddr = {5'd0, 5'd9};
    sample();
    chk("r9_pending", {63'd0, rv_b[0]}, 64'd0);
    tick();
    we = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'd0, 32'd5};
    sample();
    chk("r9_byp_valid", {63'd0, rv_b[0]}, 64'd1);
    chk("r9_byp_data", {32'd0, rd_b[31:0]}, 64'd5);
    chk("r9_nobyp_pending", {63'd0, rv_n[0]}, 64'd0);
    tick();
    idle();
    re = 2'b01; raddr = {5'd0, 5'd9};
    sample();
    chk("r9_cleared", {63'd0, rv_n[0]}, 64'd1);
    tick();

    // Set/clear collision.
    idle();
    mark = 1'b1; mark_addr = 5'd4;
    we = 2'b10; waddr = {5'd4, 5'd0}; wdata = {32'h44, 32'd0};
    cycle();
    idle();
    re = 2'b10; raddr = {5'd4, 5'd0};
    sample();
    chk("collide_valid", {63'd0, rv_b[1]}, 64'd0);
    chk("collide_data", {32'd0, rd_b[63:32]}, 64'h44);
    tick();

    // Register 0.
    idle();
    we = 2'b01; waddr = {5'd0, 5'd0}; wdata = {32'd0, 32'hFF};
    mark = 1'b1; mark_addr = 5'd0;
    re = 2'b11; raddr = {5'd0, 5'd0};
    cycle();
    idle();
    re = 2'b01; raddr = {5'd0, 5'd0};
    sample();
    chk("r0_data", {32'd0, rd_b[31:0]}, 64'd0);
    chk("r0_valid", {63'd0, rv_b[0]}, 64'd1);
    tick();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      we        = 2'($urandom_range(0, 3));
      waddr     = {5'($urandom_range(0, 11)), 5'($urandom_range(0, 11))};
      wdata     = {$urandom, $urandom};
      re        = 2'($urandom_range(0, 3));
      raddr     = {5'($urandom_range(0, 11)), 5'($urandom_range(0, 31))};
      mark      = ($urandom_range(0, 2) == 0);
      mark_addr = 5'($urandom_range(0, 11));
      cycle();
    end

    // Mid-sweep reset: assert rst with the sweep counter at 10.
    idle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    re = 2'b11; raddr = {5'd3, 5'd7};
    for (int n = 0; n < 9; n++) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    count_sweep("resweep_edges");
    idle();
    re = 2'b11; raddr = {5'd7, 5'd3};
    sample();
    chk("r3_zero_after_resweep", {32'd0, rd_b[31:0]}, 64'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port general-purpose register file, successor to the 2R/1W CPU register file.
- Adds configurable read/write port counts, deterministic write-port priority, optional same-cycle write-to-read bypass and a per-register pending scoreboard for hazard detection.
- Adds a post-reset clearing sweep, so every register powers up at zero.
- Sits between decode (reads, pending marks) and writeback (writes) in the pipeline.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, number of registers; must be ≤ 2**ADDR_W. Register 0 is hardwired to zero.
- NUM_RD, 2, number of read ports.
- NUM_WR, 2, number of write ports.
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching reads.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- we  in  NUM_WR  per-port write enable.
- waddr  in  NUM_WR*ADDR_W  write addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- wdata  in  NUM_WR*DATA_W  write data, packed the same way.
- re  in  NUM_RD  per-port read enable.
- raddr  in  NUM_RD*ADDR_W  read addresses.
- rdata  out  NUM_RD*DATA_W  read data (combinational).
- rvalid  out  NUM_RD  read operand is valid, i.e. not pending.
- mark  in  1  marks register mark_addr as pending (new in-flight producer).
- mark_addr  in  ADDR_W  register to mark.
- init_done  out  1  high once the clearing sweep has completed.

Behaviour:
- FSM states are CLEAR and RUN.
  - rst=1 forces CLEAR with sweep counter = 1 and all pending bits = 0 at the next edge. This also applies mid-sweep or mid-run; the sweep restarts from 1.
  - In CLEAR, one register is written to zero per cycle, from 1 up to NUM_REGS-1. After writing NUM_REGS-1 the FSM enters RUN.
  - The sweep takes NUM_REGS-1 cycles after rst deasserts. For NUM_REGS=32, init_done rises on the 31st edge after the first edge with rst=0.
- init_done is 0 during reset and CLEAR, and 1 in RUN.
- While in CLEAR, or while rst=1:
  - we and mark are ignored.
  - rdata = 0 and rvalid = 0 for all ports.
- Writes in RUN:
  - Writes take effect at the rising edge.
  - Writes to address 0, or to addresses ≥ NUM_REGS, are dropped.
  - If several enabled ports target the same address, the highest-index port wins.
- Reads in RUN are combinational. For each port i:
  - re[i]=0 gives rdata=0 and rvalid=0.
  - raddr=0, or raddr ≥ NUM_REGS, gives rdata=0 and rvalid=1.
  - If BYPASS=1 and some enabled write this cycle hits raddr, rdata = the winning port's wdata and rvalid = 1, regardless of the pending bit.
  - Otherwise rdata = the stored value and rvalid = !pending[raddr].
- Scoreboard, pending[NUM_REGS], updated at the edge in RUN only:
  - A write to register r clears pending[r].
  - mark sets pending[mark_addr].
  - If a set and a clear hit the same register in the same cycle, the set wins, because the newer producer takes precedence.
  - pending[0] is always 0; marks to 0 or to an out-of-range address are ignored.
- BYPASS=0: reads see only stored values; a same-cycle write becomes visible the next cycle. rvalid still reflects the pre-edge pending bit.
- Latency:
  - Read: 0 cycles.
  - Write visible at the next edge; same cycle when bypassed.
  - Pending bit set/cleared at the next edge.

Decomposition:
- The shared defines package holds:
  - RstEnable / WriteEnable / ReadEnable / ZeroWord constants.
  - Default DATA_W/ADDR_W/NUM_REGS values.
  - FSM state encodings ST_CLEAR and ST_RUN.
- One sub-module, regfile_wr_arb:
  - Per-address write resolution: winning-port select, with bypass data and hit flags for one read address.
  - Instantiated once per read port and reused for the storage write decode.

Test Plan:
- Post-reset sweep: NUM_REGS=32, rst high 2 cycles then low → init_done low for exactly 31 edges. During the sweep, we[0]=1 to r5 is ignored. After init_done, a read of r5 returns 0.
- Write priority: one cycle with we=2'b11, waddr0=waddr1=7, wdata0=0x11, wdata1=0x22 → next cycle r7 reads 0x22.
- Bypass: BYPASS=1, write r3=0xDEAD while raddr0=3 in the same cycle → rdata0=0xDEAD and rvalid0=1 that cycle. With BYPASS=0 the same stimulus gives the old value that cycle and 0xDEAD the next.
- Scoreboard: mark r9 → next cycle a read of r9 gives rvalid=0. Write r9=5 → bypassed read gives rvalid=1 and rdata=5. The following cycle pending[9] is clear.
- Set/clear collision: mark r4 and write r4 in the same cycle → next cycle a read of r4 gives rvalid=0 and rdata = the written value.
- Register 0 and mid-sweep reset:
  - Write r0=0xFF and mark r0 → r0 reads 0 with rvalid=1.
  - Assert rst at sweep count 10 → sweep restarts, and init_done needs 31 more edges after rst deasserts.
